frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: frames an upstream pixel stream into vsync/pixels/hsync/flush beats for a detection pipeline.
// Optional statistics outputs (frame_count, stall_count) are enabled by defining FRAME_SEQUENCER_STATS_EN.
module frame_sequencer #(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned PIXEL_SIZE   = 24,
  parameter int unsigned LATENCY      = 2 * FRAME_WIDTH + 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [PIXEL_SIZE-1:0] in_data,
  output logic                  in_ready,
  output logic                  pipe_en,
  output logic                  pipe_hsync,
  output logic                  pipe_vsync,
  output logic [PIXEL_SIZE-1:0] pipe_data,
  output logic                  pipe_out_valid,
  output logic                  busy,
  output logic                  frame_done
`ifdef FRAME_SEQUENCER_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int unsigned COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned LAT_W = $clog2(LATENCY + 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [LAT_W-1:0] LAT_MAX   = LAT_W'(LATENCY);
  localparam logic [LAT_W-1:0] FLUSH_END = LAT_W'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, SOF, ACTIVE, EOL, FLUSH, DONE} state_t;

  state_t                r_state, w_state;
  logic [COL_W-1:0]      r_col, w_col;
  logic [ROW_W-1:0]      r_row, w_row;
  logic [LAT_W-1:0]      r_flush_cnt, w_flush_cnt;
  logic [LAT_W-1:0]      r_en_cnt, w_en_cnt;
  logic                  r_pipe_en, w_pipe_en;
  logic                  r_hsync, w_hsync;
  logic                  r_vsync, w_vsync;
  logic [PIXEL_SIZE-1:0] r_data, w_data;
  logic                  r_done, w_done;

  // State and registered pipeline outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_flush_cnt <= '0;
      r_en_cnt    <= '0;
      r_pipe_en   <= 1'b0;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_data      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_col       <= w_col;
      r_row       <= w_row;
      r_flush_cnt <= w_flush_cnt;
      r_en_cnt    <= w_en_cnt;
      r_pipe_en   <= w_pipe_en;
      r_hsync     <= w_hsync;
      r_vsync     <= w_vsync;
      r_data      <= w_data;
      r_done      <= w_done;
    end
  end

  // Next-state and next-output logic; pipe_data holds unless a beat is issued.
  always_comb begin
    w_state     = r_state;
    w_col       = r_col;
    w_row       = r_row;
    w_flush_cnt = '0;
    w_en_cnt    = r_en_cnt;
    w_pipe_en   = 1'b0;
    w_hsync     = 1'b0;
    w_vsync     = 1'b0;
    w_data      = r_data;
    w_done      = 1'b0;

    if (r_pipe_en && (r_en_cnt < LAT_MAX)) begin
      w_en_cnt = r_en_cnt + LAT_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state = SOF;
        end
      end
      SOF: begin
        w_col     = '0;
        w_row     = '0;
        w_en_cnt  = '0;
        w_pipe_en = 1'b1;
        w_vsync   = 1'b1;
        w_data    = '0;
        w_state   = ACTIVE;
      end
      ACTIVE: begin
        if (in_valid) begin
          w_pipe_en = 1'b1;
          w_data    = in_data;
          if (r_col == COL_MAX) begin
            w_col   = '0;
            w_state = (r_row < ROW_MAX) ? EOL : FLUSH;
          end else begin
            w_col = r_col + COL_W'(1);
          end
        end
      end
      EOL: begin
        w_pipe_en = 1'b1;
        w_hsync   = 1'b1;
        w_data    = '0;
        w_row     = r_row + ROW_W'(1);
        w_state   = ACTIVE;
      end
      FLUSH: begin
        w_pipe_en = 1'b1;
        w_data    = '0;
        if (r_flush_cnt == FLUSH_END) begin
          w_state = DONE;
        end else begin
          w_flush_cnt = r_flush_cnt + LAT_W'(1);
        end
      end
      DONE: begin
        w_done  = 1'b1;
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign in_ready       = (r_state == ACTIVE);
  assign busy           = (r_state != IDLE);
  assign pipe_en        = r_pipe_en;
  assign pipe_hsync     = r_hsync;
  assign pipe_vsync     = r_vsync;
  assign pipe_data      = r_data;
  assign frame_done     = r_done;
  assign pipe_out_valid = r_pipe_en && (r_en_cnt >= LAT_MAX);

`ifdef FRAME_SEQUENCER_STATS_EN
  logic [15:0] r_frame_count;
  logic [31:0] r_stall_count;

  // Frame counter wraps; stall counter restarts each frame and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_state == DONE) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (r_state == SOF) begin
        r_stall_count <= '0;
      end else if ((r_state == ACTIVE) && !in_valid && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign stall_count = r_stall_count;
`else
  // Statistics disabled: no extra ports or state.
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer (4x3 frame, LATENCY 6): vector table plus scoreboarded frames.
module tb_frame_sequencer;
  localparam int unsigned FW  = 4;
  localparam int unsigned FH  = 3;
  localparam int unsigned PS  = 24;
  localparam int unsigned LAT = 6;
  localparam int unsigned NEN = 1 + FW * FH + (FH - 1) + LAT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid;
  logic [PS-1:0] in_data;
  logic          in_ready, pipe_en, pipe_hsync, pipe_vsync, pipe_out_valid, busy, frame_done;
  logic [PS-1:0] pipe_data;
`ifdef FRAME_SEQUENCER_STATS_EN
  logic [15:0]   frame_count;
  logic [31:0]   stall_count;
`endif

  int checks = 0;
  int errors = 0;

  frame_sequencer #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .PIXEL_SIZE  (PS),
    .LATENCY     (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .pipe_en       (pipe_en),
    .pipe_hsync    (pipe_hsync),
    .pipe_vsync    (pipe_vsync),
    .pipe_data     (pipe_data),
    .pipe_out_valid(pipe_out_valid),
    .busy          (busy),
    .frame_done    (frame_done)
`ifdef FRAME_SEQUENCER_STATS_EN
    ,
    .frame_count   (frame_count),
    .stall_count   (stall_count)
`endif
  );

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic [PS-1:0] d;
  } ev_t;

  typedef struct {
    logic          rst;
    logic          st;
    logic          v;
    logic [PS-1:0] d;
    logic [31:0]   exp;
  } vec_t;

  ev_t exp_q[$];

  function automatic logic [31:0] pk(input logic ir, input logic bz, input logic en, input logic hs,
                                     input logic vs, input logic ov, input logic fd, input logic [PS-1:0] d);
    return 32'({ir, bz, en, hs, vs, ov, fd, d});
  endfunction

  function automatic logic [31:0] act_pk();
    return pk(in_ready, busy, pipe_en, pipe_hsync, pipe_vsync, pipe_out_valid, frame_done, pipe_data);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic v, input logic [PS-1:0] d);
    reset    = r;
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // One frame: pixels base+1.. ; optional stall after stall_at pixels; optional reset after rst_at pixels.
  task automatic run_frame(input int base, input int stall_at, input int stall_len, input int rst_at);
    int            pi;
    int            en_idx;
    int            gaps;
    int            rem;
    int            budget;
    bit            done;
    logic          v;
    logic          prev_en;
    logic          last_ir;
    logic [PS-1:0] last_data;
    logic [PS-1:0] d;
    ev_t           e;
    pi = 0; en_idx = 0; gaps = 0; rem = stall_len; budget = 0; done = 1'b0;
    exp_q.delete();
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("start_state", 64'({busy, in_ready, frame_done}), 64'(3'b100));
    e = '{hs: 1'b0, vs: 1'b1, d: '0};
    exp_q.push_back(e);
    prev_en = pipe_en; last_ir = in_ready; last_data = pipe_data;
    while (!done && budget < 200) begin
      budget++;
      d = PS'(base + pi + 1);
      if (rst_at >= 0 && pi == rst_at) begin
        cyc(1'b1, 1'b1, 1'b1, d);
        check("reset_abort", 64'(act_pk()), 64'(0));
        return;
      end
      v = 1'b1;
      if (pi == stall_at && rem > 0 && last_ir) begin
        v = 1'b0;
        rem--;
      end
      if (v && last_ir) begin
        e = '{hs: 1'b0, vs: 1'b0, d: d};
        exp_q.push_back(e);
        if ((pi % FW) == FW - 1) begin
          if ((pi / FW) < FH - 1) begin
            e = '{hs: 1'b1, vs: 1'b0, d: '0};
            exp_q.push_back(e);
          end else begin
            for (int k = 0; k < LAT; k++) begin
              e = '{hs: 1'b0, vs: 1'b0, d: '0};
              exp_q.push_back(e);
            end
          end
        end
        pi++;
      end
      cyc(1'b0, 1'b0, v, d);
      if (pipe_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pipe_en", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("pipe_beat", 64'({pipe_hsync, pipe_vsync, pipe_data}), 64'(e));
          check("out_valid", 64'(pipe_out_valid), 64'(en_idx >= LAT));
        end
        en_idx++;
      end else begin
        check("idle_hold", 64'({pipe_hsync, pipe_vsync, pipe_out_valid, pipe_data}), 64'({3'b000, last_data}));
        if (en_idx > 0 && !frame_done) gaps++;
      end
      check("busy", 64'(busy), 64'(!frame_done));
      if (frame_done) begin
        check("done_timing", 64'({prev_en, pipe_en, 32'(en_idx)}), 64'({1'b1, 1'b0, 32'(NEN)}));
        done = 1'b1;
      end
      prev_en = pipe_en; last_ir = in_ready; last_data = pipe_data;
    end
    if (!done) check("frame_timeout", 64'(0), 64'(1));
    check("en_count", 64'(en_idx), 64'(NEN));
    check("stall_gaps", 64'(gaps), 64'(stall_len));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  vec_t tbl[10];
  int   bad;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 24'h000000, pk(0, 0, 0, 0, 0, 0, 0, 24'h0)};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 24'h0000AA, pk(0, 0, 0, 0, 0, 0, 0, 24'h0)};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 24'h000011, pk(0, 1, 0, 0, 0, 0, 0, 24'h0)};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 24'h000011, pk(1, 1, 1, 0, 1, 0, 0, 24'h0)};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 24'h000011, pk(1, 1, 1, 0, 0, 0, 0, 24'h11)};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 24'h000033, pk(1, 1, 0, 0, 0, 0, 0, 24'h11)};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 24'h000022, pk(1, 1, 1, 0, 0, 0, 0, 24'h22)};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 24'h000000, pk(1, 1, 0, 0, 0, 0, 0, 24'h22)};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 24'h000044, pk(0, 0, 0, 0, 0, 0, 0, 24'h0)};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 24'h000000, pk(0, 0, 0, 0, 0, 0, 0, 24'h0)};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].v, tbl[i].d);
      check($sformatf("vec%0d", i), 64'(act_pk()), 64'(tbl[i].exp));
    end
`ifdef FRAME_SEQUENCER_STATS_EN
    check("stats_reset", 64'({frame_count, stall_count}), 64'(0));
`endif

    run_frame(0, -1, 0, -1);
    cyc(1'b0, 1'b0, 1'b1, '0);
    check("after_frame_idle", 64'({frame_done, busy, pipe_en}), 64'(0));
`ifdef FRAME_SEQUENCER_STATS_EN
    check("frame_count_1", 64'(frame_count), 64'(1));
    check("stall_count_0", 64'(stall_count), 64'(0));
`endif

    run_frame(100, 5, 3, -1);
`ifdef FRAME_SEQUENCER_STATS_EN
    check("stall_count_3", 64'(stall_count), 64'(3));
`endif

    run_frame(0, -1, 0, 5);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b1, PS'(i));
      if (pipe_en || frame_done || busy || in_ready) bad++;
    end
    check("abort_stays_idle", 64'(bad), 64'(0));
`ifdef FRAME_SEQUENCER_STATS_EN
    check("frame_count_cleared", 64'(frame_count), 64'(0));
`endif

    run_frame(200, -1, 0, -1);
    run_frame(300, -1, 0, -1);
`ifdef FRAME_SEQUENCER_STATS_EN
    check("frame_count_2", 64'(frame_count), 64'(2));
`endif
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("final_idle", 64'(act_pk()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
